// File: rtl/rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI retire-trace buffer: the stored retire packet and
// the capture state.
package rvfi_trace_buffer_pkg;

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] insn;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  mem_wmask;
    } trace_pkt_t;

    typedef enum logic {
        TRACE_RUN    = 1'b0,
        TRACE_HALTED = 1'b1
    } trace_state_e;

    localparam int PKT_W = $bits(trace_pkt_t);

    // x0 writes are architecturally invisible, so the trace records them as zero.
    function automatic trace_pkt_t make_pkt(
        input logic [31:0] order,
        input logic [31:0] insn,
        input logic [31:0] pc_rdata,
        input logic [31:0] pc_wdata,
        input logic [31:0] rd_wdata,
        input logic [31:0] mem_addr,
        input logic [4:0]  rd_addr,
        input logic [3:0]  mem_wmask
    );
        trace_pkt_t p;
        p.order     = order;
        p.insn      = insn;
        p.pc_rdata  = pc_rdata;
        p.pc_wdata  = pc_wdata;
        p.rd_wdata  = (rd_addr == 5'd0) ? 32'd0 : rd_wdata;
        p.mem_addr  = mem_addr;
        p.rd_addr   = rd_addr;
        p.mem_wmask = mem_wmask;
        return p;
    endfunction

endpackage

// File: rtl/rvfi_trace_buffer_if.sv
// Retire-side and consumer-side signals of the trace buffer.
// in_valid is a one-cycle retire strobe with no back-pressure; the output side is
// valid/ready: a packet transfers on a rising edge where out_valid and out_ready are
// both 1, and out_* stays stable while out_valid=1 and out_ready=0.
interface rvfi_trace_buffer_if;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [31:0] in_pc_rdata;
    logic [31:0] in_pc_wdata;
    logic [31:0] in_rd_wdata;
    logic [31:0] in_mem_addr;
    logic [4:0]  in_rd_addr;
    logic [3:0]  in_mem_wmask;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_order;
    logic [31:0] out_insn;
    logic [31:0] out_pc_rdata;
    logic [31:0] out_pc_wdata;
    logic [31:0] out_rd_wdata;
    logic [31:0] out_mem_addr;
    logic [4:0]  out_rd_addr;
    logic [3:0]  out_mem_wmask;

    modport master (
        output in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_rd_wdata,
               in_mem_addr, in_rd_addr, in_mem_wmask, out_ready,
        input  out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
               out_rd_wdata, out_mem_addr, out_rd_addr, out_mem_wmask
    );

    modport slave (
        input  in_valid, in_insn, in_pc_rdata, in_pc_wdata, in_rd_wdata,
               in_mem_addr, in_rd_addr, in_mem_wmask, out_ready,
        output out_valid, out_order, out_insn, out_pc_rdata, out_pc_wdata,
               out_rd_wdata, out_mem_addr, out_rd_addr, out_mem_wmask
    );
endinterface

// File: rtl/rvfi_trace_buffer_fifo_mem.sv
// Packet storage for the trace buffer: register array, one synchronous write
// port and one asynchronous read port.
module trace_fifo_mem
    import rvfi_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  trace_pkt_t               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output trace_pkt_t               rdata
);
    trace_pkt_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/rvfi_trace_buffer.sv
// RVFI retire-trace FIFO: stamps every retire with a sequence number, buffers
// accepted packets and counts the ones it has to drop.
module rvfi_trace_buffer
    import rvfi_trace_buffer_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter bit STOP_ON_OVF = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    rvfi_trace_buffer_if.slave     bus,
    input  logic                   clear_ovf,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [15:0]            drop_count,
    output trace_state_e           dbg_state
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [31:0]  order_cnt;
    trace_state_e state, state_next;
    logic         full, empty, push, pop, drop;
    trace_pkt_t   wr_pkt, rd_pkt, head_pkt;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && bus.out_ready;
    // A full buffer still accepts when the head leaves on the same edge.
    assign push  = bus.in_valid && (state == TRACE_RUN) && (!full || pop);
    assign drop  = bus.in_valid && !push;

    assign wr_pkt = make_pkt(order_cnt, bus.in_insn, bus.in_pc_rdata, bus.in_pc_wdata,
                             bus.in_rd_wdata, bus.in_mem_addr, bus.in_rd_addr,
                             bus.in_mem_wmask);

    trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_pkt),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_pkt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            order_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (bus.in_valid) order_cnt <= order_cnt + 32'd1;
            // A drop in the clearing cycle is counted as the first of a new run.
            if (clear_ovf) begin
                overflow   <= drop;
                drop_count <= {15'd0, drop};
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= TRACE_RUN;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            TRACE_RUN:    if (drop && STOP_ON_OVF) state_next = TRACE_HALTED;
            TRACE_HALTED: if (clear_ovf && !drop) state_next = TRACE_RUN;
            default:      state_next = TRACE_RUN;
        endcase
    end

    assign head_pkt          = empty ? '0 : rd_pkt;
    assign bus.out_valid     = !empty;
    assign bus.out_order     = head_pkt.order;
    assign bus.out_insn      = head_pkt.insn;
    assign bus.out_pc_rdata  = head_pkt.pc_rdata;
    assign bus.out_pc_wdata  = head_pkt.pc_wdata;
    assign bus.out_rd_wdata  = head_pkt.rd_wdata;
    assign bus.out_mem_addr  = head_pkt.mem_addr;
    assign bus.out_rd_addr   = head_pkt.rd_addr;
    assign bus.out_mem_wmask = head_pkt.mem_wmask;

    assign level     = wr_ptr - rd_ptr;
    assign dbg_state = state;
endmodule
